// File: rtl/arx_clock_divider_bank.sv
// Multi-channel programmable clock-enable / divided-clock generator.
// Divisor changes land on period boundaries; sync_all realigns every channel at once.
module arx_clock_divider_bank #(
   parameter int unsigned                 NUM_CH      = 3,
   parameter int unsigned                 DIV_WIDTH   = 8,
   parameter logic [NUM_CH*DIV_WIDTH-1:0] DEF_DIV     = {8'd4, 8'd2, 8'd1},
   parameter int unsigned                 LOCK_CYCLES = 16,
   localparam int unsigned                CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   input  logic [CH_W-1:0]      cfg_ch,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   input  logic                 sync_all,
   output logic [NUM_CH-1:0]    clk_en,
   output logic [NUM_CH-1:0]    clk_div,
   output logic [NUM_CH-1:0]    cfg_pending,
   output logic                 cfg_err,
   output logic                 locked
);

   localparam int unsigned   LW       = $clog2(LOCK_CYCLES + 1);
   localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

   logic [DIV_WIDTH-1:0] div_q  [NUM_CH];
   logic [DIV_WIDTH-1:0] div_d  [NUM_CH];
   logic [DIV_WIDTH-1:0] pdiv_q [NUM_CH];
   logic [DIV_WIDTH-1:0] pdiv_d [NUM_CH];
   logic [DIV_WIDTH-1:0] ph_q   [NUM_CH];
   logic [DIV_WIDTH-1:0] ph_d   [NUM_CH];
   logic [DIV_WIDTH-1:0] ph_nxt [NUM_CH];

   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] hi_q, hi_d;
   logic [NUM_CH-1:0] wr_sel;
   logic [LW-1:0]     lock_q, lock_d;
   logic              locked_q;
   logic              err_q;
   logic              wr_ok;

   function automatic logic [DIV_WIDTH-1:0] phase_after(input logic [DIV_WIDTH-1:0] d,
                                                        input logic [DIV_WIDTH-1:0] p);
      return (p == d - 1'b1) ? '0 : p + 1'b1;
   endfunction

   // High for phases 1..ceil(D/2); a divide-by-1 channel is held high.
   function automatic logic high_phase(input logic [DIV_WIDTH-1:0] d,
                                       input logic [DIV_WIDTH-1:0] p);
      logic [DIV_WIDTH:0] half;
      half = ({1'b0, d} + 1'b1) >> 1;
      return (d == DIV_WIDTH'(1)) || ((p != '0) && ({1'b0, p} <= half));
   endfunction

   always_comb begin
      wr_ok = cfg_valid && (32'(cfg_ch) < NUM_CH);
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         wr_sel[c] = wr_ok && (32'(cfg_ch) == c);
         ph_nxt[c] = phase_after(div_q[c], ph_q[c]);
      end
   end

   always_comb begin
      pend_d = pend_q;
      en_d   = '0;
      hi_d   = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         div_d[c]  = div_q[c];
         pdiv_d[c] = pdiv_q[c];
         ph_d[c]   = ph_q[c];
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (sync_all) begin
            // A same-cycle write is newer than any pending value, so it wins.
            if (wr_sel[c]) begin
               div_d[c] = cfg_div;
            end else if (pend_q[c]) begin
               div_d[c] = pdiv_q[c];
            end
            pend_d[c] = 1'b0;
            ph_d[c]   = '0;
            en_d[c]   = (div_d[c] != '0);
         end else if (div_q[c] == '0) begin
            ph_d[c] = '0;
            if (wr_sel[c]) begin
               div_d[c] = cfg_div;
            end
         end else begin
            ph_d[c] = ph_nxt[c];
            en_d[c] = (ph_nxt[c] == '0);
            hi_d[c] = high_phase(div_q[c], ph_nxt[c]);
            // Only a divisor that was already pending before this edge may swap in.
            if ((ph_nxt[c] == '0) && pend_q[c]) begin
               div_d[c]  = pdiv_q[c];
               pend_d[c] = 1'b0;
            end
            if (wr_sel[c]) begin
               pend_d[c] = 1'b1;
               pdiv_d[c] = cfg_div;
            end
         end
      end
   end

   always_comb begin
      lock_d = lock_q;
      if (wr_ok) begin
         lock_d = '0;
      end else if ((pend_q == '0) && (lock_q != LOCK_MAX)) begin
         lock_d = lock_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            div_q[c]  <= DEF_DIV[c*DIV_WIDTH +: DIV_WIDTH];
            pdiv_q[c] <= '0;
            ph_q[c]   <= '0;
         end
         pend_q   <= '0;
         en_q     <= '0;
         hi_q     <= '0;
         lock_q   <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            div_q[c]  <= div_d[c];
            pdiv_q[c] <= pdiv_d[c];
            ph_q[c]   <= ph_d[c];
         end
         pend_q   <= pend_d;
         en_q     <= en_d;
         hi_q     <= hi_d;
         lock_q   <= lock_d;
         locked_q <= (lock_d == LOCK_MAX);
         err_q    <= cfg_valid && (32'(cfg_ch) >= NUM_CH);
      end
   end

   assign clk_en      = en_q;
   assign clk_div     = hi_q;
   assign cfg_pending = pend_q;
   assign cfg_err     = err_q;
   assign locked      = locked_q;

endmodule

// File: tb/tb_arx_clock_divider_bank.sv
// Bench for arx_clock_divider_bank: arithmetic per-channel model (phase = edges since
// period start mod D) compared every cycle, plus literal pins on the directed timeline.
module tb_arx_clock_divider_bank;

   localparam int NCH   = 3;
   localparam int LOCKN = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_valid = 1'b0;
   logic [1:0] cfg_ch = '0;
   logic [7:0] cfg_div = '0;
   logic       sync_all = 1'b0;
   logic [2:0] clk_en, clk_div, cfg_pending;
   logic       cfg_err, locked;

   int n_chk  = 0;
   int n_fail = 0;

   arx_clock_divider_bank #(
      .NUM_CH     (3),
      .DIV_WIDTH  (8),
      .DEF_DIV    ({8'd4, 8'd2, 8'd1}),
      .LOCK_CYCLES(16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ch     (cfg_ch),
      .cfg_div    (cfg_div),
      .sync_all   (sync_all),
      .clk_en     (clk_en),
      .clk_div    (clk_div),
      .cfg_pending(cfg_pending),
      .cfg_err    (cfg_err),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   // Model state: divisor, edge at which the current period began, pending write.
   int         n, last_bad;
   int         mD [NCH];
   int         ms [NCH];
   int         mpv[NCH];
   bit         mpend[NCH];
   logic [2:0] m_en, m_dv, m_pend;
   logic       m_err, m_lock;
   bit         chk_on = 1'b0;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, n);
      end
   endtask

   task automatic pin(input string name, input logic [7:0] dutv, input logic [7:0] mdlv,
                      input logic [7:0] lit);
      check({name, " dut"}, dutv, lit);
      check({name, " model"}, mdlv, lit);
   endtask

   task automatic model_reset();
      n = 0;
      last_bad = 0;
      mD[0] = 1; mD[1] = 2; mD[2] = 4;
      for (int c = 0; c < NCH; c++) begin
         ms[c] = 0; mpv[c] = 0; mpend[c] = 1'b0;
      end
      m_en = '0; m_dv = '0; m_pend = '0; m_err = 1'b0; m_lock = 1'b0;
   endtask

   task automatic model_step();
      bit wr, any_pend, hit;
      int q;
      n++;
      wr = cfg_valid && (int'(cfg_ch) < NCH);
      m_err = cfg_valid && (int'(cfg_ch) >= NCH);
      any_pend = 1'b0;
      for (int c = 0; c < NCH; c++) any_pend |= mpend[c];
      if (wr || any_pend) last_bad = n;
      for (int c = 0; c < NCH; c++) begin
         hit = wr && (int'(cfg_ch) == c);
         if (sync_all) begin
            if (hit) mD[c] = int'(cfg_div);
            else if (mpend[c]) mD[c] = mpv[c];
            mpend[c] = 1'b0;
            ms[c] = n;
            m_en[c] = (mD[c] != 0);
            m_dv[c] = 1'b0;
         end else if (mD[c] == 0) begin
            m_en[c] = 1'b0;
            m_dv[c] = 1'b0;
            if (hit) begin
               mD[c] = int'(cfg_div);
               ms[c] = n;
            end
         end else begin
            q = (n - ms[c]) % mD[c];
            m_en[c] = (q == 0);
            m_dv[c] = (mD[c] == 1) || (q >= 1 && q <= (mD[c] + 1) / 2);
            if (q == 0 && mpend[c]) begin
               mD[c] = mpv[c];
               mpend[c] = 1'b0;
               ms[c] = n;
            end
            if (hit) begin
               mpend[c] = 1'b1;
               mpv[c] = int'(cfg_div);
            end
         end
         m_pend[c] = mpend[c];
      end
      m_lock = (n - last_bad) >= LOCKN;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   always @(negedge clk) begin
      if (chk_on && !rst) begin
         check("clk_en", {5'd0, clk_en}, {5'd0, m_en});
         check("clk_div", {5'd0, clk_div}, {5'd0, m_dv});
         check("cfg_pending", {5'd0, cfg_pending}, {5'd0, m_pend});
         check("cfg_err", {7'd0, cfg_err}, {7'd0, m_err});
         check("locked", {7'd0, locked}, {7'd0, m_lock});
      end
   end

   task automatic cyc(input logic v, input int ch, input int d, input logic s);
      cfg_valid = v;
      cfg_ch    = 2'(ch);
      cfg_div   = 8'(d);
      sync_all  = s;
      @(negedge clk);
      cfg_valid = 1'b0;
      sync_all  = 1'b0;
   endtask

   task automatic idle(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic idle_until(input int e);
      for (int k = 0; k < 1000 && n < e; k++) @(negedge clk);
      check("edge_reached", 8'(n == e), 8'd1);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst clk_en", {5'd0, clk_en}, 8'd0);
      check("rst clk_div", {5'd0, clk_div}, 8'd0);
      check("rst locked", {7'd0, locked}, 8'd0);
      rst = 1'b0;
      chk_on = 1'b1;

      idle_until(1);
      pin("e1 clk_en", {5'd0, clk_en}, {5'd0, m_en}, 8'b001);
      pin("e1 clk_div", {5'd0, clk_div}, {5'd0, m_dv}, 8'b111);
      idle_until(4);
      pin("e4 clk_en", {5'd0, clk_en}, {5'd0, m_en}, 8'b111);
      pin("e4 clk_div", {5'd0, clk_div}, {5'd0, m_dv}, 8'b001);
      idle_until(15);
      pin("e15 locked", {7'd0, locked}, {7'd0, m_lock}, 8'd0);
      idle_until(16);
      pin("e16 locked", {7'd0, locked}, {7'd0, m_lock}, 8'd1);

      // ch2 div=3 written at phase 1; old period ends at edge 20
      cyc(1'b1, 2, 3, 1'b0);
      pin("e17 pending", {5'd0, cfg_pending}, {5'd0, m_pend}, 8'b100);
      pin("e17 locked", {7'd0, locked}, {7'd0, m_lock}, 8'd0);
      idle_until(19);
      pin("e19 clk_en", {5'd0, clk_en}, {5'd0, m_en}, 8'b001);
      idle_until(20);
      pin("e20 clk_en", {5'd0, clk_en}, {5'd0, m_en}, 8'b111);
      pin("e20 pending", {5'd0, cfg_pending}, {5'd0, m_pend}, 8'b000);
      idle_until(21);
      pin("e21 clk_div", {5'd0, clk_div}, {5'd0, m_dv}, 8'b111);
      idle_until(23);
      pin("e23 clk_en", {5'd0, clk_en}, {5'd0, m_en}, 8'b101);
      pin("e23 clk_div", {5'd0, clk_div}, {5'd0, m_dv}, 8'b011);
      idle_until(35);
      pin("e35 locked", {7'd0, locked}, {7'd0, m_lock}, 8'd0);
      idle_until(36);
      pin("e36 locked", {7'd0, locked}, {7'd0, m_lock}, 8'd1);

      cyc(1'b1, 3, 9, 1'b0);
      pin("e37 cfg_err", {7'd0, cfg_err}, {7'd0, m_err}, 8'd1);
      pin("e37 locked", {7'd0, locked}, {7'd0, m_lock}, 8'd1);
      idle(1);
      pin("e38 cfg_err", {7'd0, cfg_err}, {7'd0, m_err}, 8'd0);

      // ch1 -> 9 at edge 40, then 5 and 7 written mid-period; 7 lands at edge 49
      cyc(1'b1, 1, 9, 1'b0);
      idle_until(41);
      cyc(1'b1, 1, 5, 1'b0);
      cyc(1'b1, 1, 7, 1'b0);
      idle_until(49);
      pin("e49 ch1 en", {7'd0, clk_en[1]}, {7'd0, m_en[1]}, 8'd1);
      idle_until(53);
      pin("e53 ch1 div", {7'd0, clk_div[1]}, {7'd0, m_dv[1]}, 8'd1);
      idle_until(54);
      pin("e54 ch1 div", {7'd0, clk_div[1]}, {7'd0, m_dv[1]}, 8'd0);
      idle_until(55);
      pin("e55 ch1 en", {7'd0, clk_en[1]}, {7'd0, m_en[1]}, 8'd0);
      idle_until(56);
      pin("e56 ch1 en", {7'd0, clk_en[1]}, {7'd0, m_en[1]}, 8'd1);

      // pending div=3 on ch1, then sync_all mid-period at edge 60
      idle_until(57);
      cyc(1'b1, 1, 3, 1'b0);
      idle_until(59);
      cyc(1'b0, 0, 0, 1'b1);
      pin("e60 clk_en", {5'd0, clk_en}, {5'd0, m_en}, 8'b111);
      pin("e60 clk_div", {5'd0, clk_div}, {5'd0, m_dv}, 8'b000);
      pin("e60 pending", {5'd0, cfg_pending}, {5'd0, m_pend}, 8'b000);
      idle_until(62);
      pin("e62 ch1 en", {7'd0, clk_en[1]}, {7'd0, m_en[1]}, 8'd0);
      idle_until(63);
      pin("e63 ch1 en", {7'd0, clk_en[1]}, {7'd0, m_en[1]}, 8'd1);

      // disable ch1 at boundary 66, re-enable with div=6 at edge 70
      cyc(1'b1, 1, 0, 1'b0);
      idle_until(68);
      pin("e68 ch1 en", {7'd0, clk_en[1]}, {7'd0, m_en[1]}, 8'd0);
      pin("e68 ch1 div", {7'd0, clk_div[1]}, {7'd0, m_dv[1]}, 8'd0);
      idle_until(69);
      cyc(1'b1, 1, 6, 1'b0);
      idle_until(75);
      pin("e75 ch1 en", {7'd0, clk_en[1]}, {7'd0, m_en[1]}, 8'd0);
      idle_until(76);
      pin("e76 ch1 en", {7'd0, clk_en[1]}, {7'd0, m_en[1]}, 8'd1);

      for (int i = 0; i < 500; i++) begin
         int r, d;
         r = int'($urandom_range(0, 99));
         if (r < 70)      d = int'($urandom_range(0, 6));
         else if (r < 95) d = int'($urandom_range(7, 20));
         else             d = int'($urandom_range(0, 255));
         cyc(($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)), d,
             ($urandom_range(0, 24) == 0));
      end

      // force ch0 active, then reset mid-cycle
      cyc(1'b1, 0, 1, 1'b1);
      idle(2);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("async rst clk_en", {5'd0, clk_en}, 8'd0);
      check("async rst clk_div", {5'd0, clk_div}, 8'd0);
      check("async rst pending", {5'd0, cfg_pending}, 8'd0);
      check("async rst locked", {7'd0, locked}, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      idle_until(4);
      pin("post-rst e4 clk_en", {5'd0, clk_en}, {5'd0, m_en}, 8'b111);
      pin("post-rst e4 clk_div", {5'd0, clk_div}, {5'd0, m_dv}, 8'b001);
      idle(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
